econv_enc_213: RTL and testbench
================================

Name: econv_enc_213

Overview:
- Rate-1/2, memory-3 (2,1,3) convolutional encoder with framing; the transmit-side counterpart of the (2,1,3) Viterbi decoder.
- Accepts a frame of BLOCK_LEN information bits over a valid/ready handshake and emits one 2-bit code symbol per bit.
- Appends M zero tail bits so every frame terminates in state 0, which the decoder's traceback relies on.
- Sits between the data source and the channel/noise model in the encoder–decoder testbench chain.

Parameters:
- M, 3, encoder memory (number of stored past bits); trellis has 2^M states.
- G0, 4'b1111, generator for code bit c0; MSB taps the current bit u_t, LSB taps u_(t-M).
- G1, 4'b1101, generator for code bit c1; same tap ordering as G0.
- BLOCK_LEN, 256, information bits per frame (>=1).
- CW, 9, width of the bit counter; must satisfy 2^CW > BLOCK_LEN.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame start request; honoured only in IDLE.
- din  in  1  information bit.
- din_valid  in  1  din is valid.
- din_ready  out  1  encoder accepts din this cycle.
- sym_out  out  2  code symbol: [1]=c0, [0]=c1.
- sym_valid  out  1  sym_out is valid.
- sym_ready  in  1  downstream consumes sym_out this cycle.
- sof  out  1  qualifies first symbol of a frame (valid only with sym_valid).
- eof  out  1  qualifies last tail symbol of a frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the eof symbol is consumed.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values: state=IDLE; shift register sr[M-1:0]=0; counters=0. Outputs: din_ready=0, sym_out=2'b00, sym_valid=0, sof=0, eof=0, busy=0, frame_done=0.
- Encoding window: w = {u, sr}, with u in the MSB. c0 = XOR-reduce(w & G0); c1 = XOR-reduce(w & G1).
- On each encode step, sr <= {u, sr[M-1:1]}.
- Output register: one-deep.
  - load_ok = !sym_valid || sym_ready.
  - A symbol loaded on edge t is visible on sym_out/sym_valid in cycle t+1 (latency 1).
  - sym_out, sof and eof hold stable while sym_valid=1 and sym_ready=0.
  - If no new symbol is loaded and sym_ready=1, sym_valid clears.
- FSM states:
  - IDLE: sr=0, bit_cnt=0, tail_cnt=0.
    - start=1 -> ENCODE.
    - din_ready=0, so din_valid is ignored, including when it arrives in the same cycle as start.
  - ENCODE: din_ready = load_ok.
    - On din_valid && din_ready: encode din, load symbol, bit_cnt++.
    - sof=1 on the symbol with bit_cnt==0.
    - When the accepted bit is number BLOCK_LEN -> FLUSH.
  - FLUSH: din_ready=0.
    - Each cycle load_ok=1: encode u=0, load symbol, tail_cnt++.
    - eof=1 on the symbol where tail_cnt==M-1; then -> DRAIN.
  - DRAIN: wait until sym_valid && sym_ready, with eof=1.
    - Then pulse frame_done for one cycle and -> IDLE.
- Symbol count: exactly BLOCK_LEN+M symbols per frame. sr ends at 0.
- Ignored inputs: start in any non-IDLE state is ignored; it is never queued.
- Stall: sym_ready held low stalls all states; no symbols are dropped or duplicated.
- Reset mid-frame: the frame is abandoned, no frame_done is issued, and the block returns to reset values on the next edge.
- BLOCK_LEN=1: sof and the single data symbol coincide, followed by M tail symbols.

Optional Feature:
ENC_ERRINJ_EN
- Defined:
  - Adds input port err_inj [1:0].
  - Every symbol loaded into the output register is XORed with err_inj sampled on that load edge. This applies to data and tail symbols alike.
  - Used to exercise the decoder's correction and out-of-sync detection.
- Undefined: the port is absent and symbols pass unmodified. Behaviour is otherwise identical.

Test Plan:
- Reset check: hold reset for 3 cycles with start=1 and din_valid=1 -> all outputs 0, busy=0, no symbol emitted.
- All-zero frame: BLOCK_LEN=4, din=0,0,0,0 with sym_ready=1 -> 7 symbols of 00; sof on the 1st, eof on the 7th; frame_done exactly 1 cycle after the 7th is consumed.
- Impulse frame: BLOCK_LEN=4, din=0,0,0,1 -> symbols 00,00,00,11,11,10,11; eof on the final 11; busy=0 after frame_done.
- Backpressure: same impulse frame with sym_ready toggling 1,0,0,1,... -> identical symbol sequence; sym_out stable whenever sym_valid=1 and sym_ready=0; din_ready=0 while stalled.
- Control robustness: pulse start during ENCODE, then apply reset after the 2nd data bit.
  - Expected: the extra start has no effect; after reset, busy=0 and no frame_done.
  - A new start then encodes a fresh frame with sr=0 (impulse response matches the impulse frame above).
- ENC_ERRINJ_EN defined: impulse frame with err_inj=2'b01 on the 4th symbol's load edge only -> symbols 00,00,00,10,11,10,11.

Source files
------------

// File: rtl/econv_enc_213_if.sv
// Handshake bundle between the (2,1,3) encoder and its source/sink.
// Groups the bit input, symbol output and frame control/status signals.
// Optional err_inj lane is present only when ENC_ERRINJ_EN is defined.
interface econv_enc_213_if;
  logic       start;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_ready;
  logic       sof;
  logic       eof;
  logic       busy;
  logic       frame_done;
`ifdef ENC_ERRINJ_EN
  logic [1:0] err_inj;
`endif

  // Source/sink side: drives requests and data, observes encoder outputs.
  modport master (
    output start, din, din_valid, sym_ready,
`ifdef ENC_ERRINJ_EN
    output err_inj,
`endif
    input  din_ready, sym_out, sym_valid, sof, eof, busy, frame_done
  );

  // Encoder side.
  modport slave (
    input  start, din, din_valid, sym_ready,
`ifdef ENC_ERRINJ_EN
    input  err_inj,
`endif
    output din_ready, sym_out, sym_valid, sof, eof, busy, frame_done
  );
endinterface

// File: rtl/econv_enc_213.sv
// Rate-1/2 (2,1,3) convolutional encoder with frame start, M zero tail bits and sof/eof marking.
// Latency 1: a symbol loaded on edge t is on sym_out in cycle t+1; one-deep output register.
// Backpressure: sym_ready low holds the output register and stalls din_ready and tail flushing.
// Optional: define ENC_ERRINJ_EN to add err_inj[1:0], XORed into every loaded symbol.
module econv_enc_213 #(
  parameter int         M         = 3,
  parameter logic [M:0] G0        = 4'b1111,
  parameter logic [M:0] G1        = 4'b1101,
  parameter int         BLOCK_LEN = 256,
  parameter int         CW        = 9
) (
  input logic          clock,
  input logic          reset,
  econv_enc_213_if.slave bus
);

  localparam int TW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENCODE,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [M-1:0]    r_sr;
  logic [CW-1:0]   r_bit_cnt;
  logic [TW-1:0]   r_tail_cnt;
  logic [1:0]      r_sym;
  logic            r_sym_vld;
  logic            r_sof;
  logic            r_eof;
  logic            r_frame_done;

  logic            w_load_ok;
  logic            w_load;
  logic            w_u;
  logic            w_sof;
  logic            w_eof;
  logic            w_din_ready;
  logic            w_done;
  logic [M:0]      w_win;
  logic [1:0]      w_sym;
  logic [1:0]      w_sym_ld;

  // The output register can take a new symbol when empty or being drained this cycle.
  assign w_load_ok = !r_sym_vld || bus.sym_ready;

  // Current bit sits in the MSB of the window; the oldest stored bit in the LSB.
  assign w_win = {w_u, r_sr};
  assign w_sym = {^(w_win & G0), ^(w_win & G1)};

`ifdef ENC_ERRINJ_EN
  assign w_sym_ld = w_sym ^ bus.err_inj;
`else
  assign w_sym_ld = w_sym;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control: which symbol to load and how to mark it.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_u         = 1'b0;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_din_ready = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_ENCODE;
      end
      S_ENCODE: begin
        w_din_ready = w_load_ok;
        if (bus.din_valid && w_load_ok) begin
          w_load = 1'b1;
          w_u    = bus.din;
          w_sof  = (r_bit_cnt == '0);
          if (r_bit_cnt == CW'(BLOCK_LEN - 1)) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Zero tail bits walk the trellis back to state 0.
        if (w_load_ok) begin
          w_load = 1'b1;
          w_u    = 1'b0;
          if (r_tail_cnt == TW'(M - 1)) begin
            w_eof       = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The eof symbol is already in the output register; wait for its consumption.
        if (r_sym_vld && bus.sym_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register and frame counters; IDLE keeps them cleared for the next frame.
  always_ff @(posedge clock) begin
    if (reset || r_state == S_IDLE) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_tail_cnt <= '0;
    end else if (w_load) begin
      r_sr <= {w_u, r_sr[M-1:1]};
      if (r_state == S_ENCODE) r_bit_cnt  <= r_bit_cnt + 1'b1;
      else                     r_tail_cnt <= r_tail_cnt + 1'b1;
    end
  end

  // One-deep output register with sof/eof travelling alongside the symbol.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sym        <= 2'b00;
      r_sym_vld    <= 1'b0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done;
      if (w_load) begin
        r_sym     <= w_sym_ld;
        r_sym_vld <= 1'b1;
        r_sof     <= w_sof;
        r_eof     <= w_eof;
      end else if (bus.sym_ready) begin
        r_sym     <= 2'b00;
        r_sym_vld <= 1'b0;
        r_sof     <= 1'b0;
        r_eof     <= 1'b0;
      end
    end
  end

  assign bus.din_ready  = w_din_ready;
  assign bus.sym_out    = r_sym;
  assign bus.sym_valid  = r_sym_vld;
  assign bus.sof        = r_sof;
  assign bus.eof        = r_eof;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_econv_enc_213.sv
// Directed bench for econv_enc_213 with BLOCK_LEN=4.
// Frames are driven cycle by cycle; consumed symbols and markers are recorded for checking.
// The error-injection scenario runs only when ENC_ERRINJ_EN is defined.
module tb_econv_enc_213;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  econv_enc_213_if bus ();

  econv_enc_213 #(
    .M(3), .G0(4'b1111), .G1(4'b1101), .BLOCK_LEN(4), .CW(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-derived impulse response for input 0,0,0,1 followed by three zero tail bits.
  localparam logic [1:0] IMP [7] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b11};
  localparam logic [1:0] IMP_ERR [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};

  // Recorded results of the last driven frame.
  logic [1:0] g_sym [16];
  logic       g_sof [16];
  logic       g_eof [16];
  int         n_sym;
  int         n_done;
  int         last_c;
  int         done_c;
  int         stab_err;
  int         rdy_err;
  logic       busy_at_done;

  task automatic set_idle_inputs();
    bus.start     = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.sym_ready = 1'b1;
`ifdef ENC_ERRINJ_EN
    bus.err_inj   = 2'b00;
`endif
  endtask

  // Drives one frame; data[i] is information bit i. bp selects the 1,0,0,1 ready pattern.
  task automatic drive_frame(input logic [3:0] data, input bit bp, input logic [1:0] inj);
    int   idx;
    int   post;
    bit   fin;
    bit   stall_prev;
    logic [1:0] prev_sym;
    logic [3:0] pat;
    pat = 4'b1001;
    idx = 0; post = 0; fin = 1'b0; stall_prev = 1'b0; prev_sym = 2'b00;
    n_sym = 0; n_done = 0; last_c = -1; done_c = -1; stab_err = 0; rdy_err = 0;
    busy_at_done = 1'bx;
    for (int i = 0; i < 16; i++) begin
      g_sym[i] = 2'bxx; g_sof[i] = 1'bx; g_eof[i] = 1'bx;
    end
    // Start cycle also offers a bit that must be ignored.
    @(posedge clock); #1;
    bus.start = 1'b1; bus.din_valid = 1'b1; bus.din = 1'b1; bus.sym_ready = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      bus.din_valid = (idx < 4);
      bus.din       = (idx < 4) ? data[idx] : 1'b0;
      bus.sym_ready = bp ? pat[c % 4] : 1'b1;
`ifdef ENC_ERRINJ_EN
      bus.err_inj   = (idx == 3) ? inj : 2'b00;
`else
      if (inj != 2'b00) bus.din_valid = bus.din_valid;
`endif
      @(negedge clock);
      if (bus.din_valid && bus.din_ready) idx++;
      if (stall_prev && (bus.sym_out !== prev_sym || bus.sym_valid !== 1'b1)) stab_err++;
      if (bus.sym_valid && !bus.sym_ready && bus.din_ready) rdy_err++;
      if (bus.sym_valid && bus.sym_ready) begin
        if (n_sym < 16) begin
          g_sym[n_sym] = bus.sym_out; g_sof[n_sym] = bus.sof; g_eof[n_sym] = bus.eof;
        end
        n_sym++;
        last_c = c;
      end
      if (bus.frame_done === 1'b1) begin
        n_done++;
        if (done_c < 0) begin done_c = c; busy_at_done = bus.busy; end
      end
      stall_prev = bus.sym_valid && !bus.sym_ready;
      prev_sym   = bus.sym_out;
      if (done_c >= 0) post++;
      if (post >= 3) fin = 1'b1;
      @(posedge clock); #1;
    end
    set_idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.din_valid = 1'b1; bus.din = 1'b1; bus.sym_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      total++;
      if ({bus.sym_out, bus.sym_valid, bus.sof, bus.eof} !== 5'b0) begin
        bad++;
        $display("FAIL reset_sym got out=%b vld=%b sof=%b eof=%b exp all 0",
                 bus.sym_out, bus.sym_valid, bus.sof, bus.eof);
      end
      total++;
      if ({bus.busy, bus.frame_done, bus.din_ready} !== 3'b000) begin
        bad++;
        $display("FAIL reset_ctl got busy=%b done=%b din_ready=%b exp 000",
                 bus.busy, bus.frame_done, bus.din_ready);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
    set_idle_inputs();
    @(negedge clock);
    total++;
    if (bus.busy !== 1'b0 || bus.sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got busy=%b vld=%b exp 0 0", bus.busy, bus.sym_valid);
    end
  endtask

  task automatic test_zero_frame();
    drive_frame(4'b0000, 1'b0, 2'b00);
    total++;
    if (n_sym !== 7) begin bad++; $display("FAIL zero_count got=%0d exp=7", n_sym); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_sym[i] !== 2'b00 || g_sof[i] !== (i == 0) || g_eof[i] !== (i == 6)) begin
        bad++;
        $display("FAIL zero_sym[%0d] got sym=%b sof=%b eof=%b exp sym=00 sof=%0d eof=%0d",
                 i, g_sym[i], g_sof[i], g_eof[i], (i == 0), (i == 6));
      end
    end
    total++;
    if (n_done !== 1 || done_c !== last_c + 1) begin
      bad++;
      $display("FAIL zero_done got pulses=%0d at=%0d exp 1 at=%0d", n_done, done_c, last_c + 1);
    end
  endtask

  task automatic test_impulse_frame();
    drive_frame(4'b1000, 1'b0, 2'b00);
    total++;
    if (n_sym !== 7) begin bad++; $display("FAIL imp_count got=%0d exp=7", n_sym); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_sym[i] !== IMP[i] || g_eof[i] !== (i == 6)) begin
        bad++;
        $display("FAIL imp_sym[%0d] got sym=%b eof=%b exp sym=%b eof=%0d",
                 i, g_sym[i], g_eof[i], IMP[i], (i == 6));
      end
    end
    total++;
    if (n_done !== 1 || busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL imp_done got pulses=%0d busy=%b exp 1 busy=0", n_done, busy_at_done);
    end
  endtask

  task automatic test_backpressure();
    drive_frame(4'b1000, 1'b1, 2'b00);
    total++;
    if (n_sym !== 7) begin bad++; $display("FAIL bp_count got=%0d exp=7", n_sym); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_sym[i] !== IMP[i] || g_sof[i] !== (i == 0) || g_eof[i] !== (i == 6)) begin
        bad++;
        $display("FAIL bp_sym[%0d] got sym=%b sof=%b eof=%b exp sym=%b sof=%0d eof=%0d",
                 i, g_sym[i], g_sof[i], g_eof[i], IMP[i], (i == 0), (i == 6));
      end
    end
    total++;
    if (stab_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0 unstable cycles", stab_err); end
    total++;
    if (rdy_err !== 0) begin bad++; $display("FAIL bp_din_ready got=%0d exp=0 stalled-ready cycles", rdy_err); end
    total++;
    if (n_done !== 1 || done_c !== last_c + 1) begin
      bad++;
      $display("FAIL bp_done got pulses=%0d at=%0d exp 1 at=%0d", n_done, done_c, last_c + 1);
    end
  endtask

  task automatic test_control();
    int dn;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.din_valid = 1'b1; bus.din = 1'b0; bus.sym_ready = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.din = 1'b0;
    @(posedge clock); #1;
    // Extra start arrives together with the second data bit.
    bus.start = 1'b1; bus.din = 1'b1;
    @(negedge clock);
    total++;
    if (bus.din_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ctl_encode got din_ready=%b busy=%b exp 1 1", bus.din_ready, bus.busy);
    end
    @(posedge clock); #1;
    bus.start = 1'b0; bus.din_valid = 1'b0;
    @(negedge clock);
    total++;
    if (bus.sym_valid !== 1'b1 || bus.sof !== 1'b0 || bus.sym_out !== 2'b11 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL ctl_second got vld=%b sof=%b sym=%b busy=%b exp 1 0 11 1",
               bus.sym_valid, bus.sof, bus.sym_out, bus.busy);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.frame_done === 1'b1) dn++;
      total++;
      if (bus.busy !== 1'b0 || bus.sym_valid !== 1'b0) begin
        bad++;
        $display("FAIL ctl_after_reset got busy=%b vld=%b exp 0 0", bus.busy, bus.sym_valid);
      end
    end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL ctl_no_done got=%0d exp=0", dn); end
    drive_frame(4'b1000, 1'b0, 2'b00);
    total++;
    if (n_sym !== 7 || n_done !== 1) begin
      bad++;
      $display("FAIL ctl_refresh_count got syms=%0d done=%0d exp 7 1", n_sym, n_done);
    end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_sym[i] !== IMP[i]) begin
        bad++;
        $display("FAIL ctl_refresh_sym[%0d] got=%b exp=%b", i, g_sym[i], IMP[i]);
      end
    end
  endtask

`ifdef ENC_ERRINJ_EN
  task automatic test_errinj();
    drive_frame(4'b1000, 1'b0, 2'b01);
    total++;
    if (n_sym !== 7) begin bad++; $display("FAIL inj_count got=%0d exp=7", n_sym); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (g_sym[i] !== IMP_ERR[i]) begin
        bad++;
        $display("FAIL inj_sym[%0d] got=%b exp=%b", i, g_sym[i], IMP_ERR[i]);
      end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    set_idle_inputs();
    test_reset();
    test_zero_frame();
    test_impulse_frame();
    test_backpressure();
    test_control();
`ifdef ENC_ERRINJ_EN
    test_errinj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
